// File: rtl/secded_pkg.sv
// Shared types and width constants for the SECDED transfer controller.
// Covers the FSM state encoding, the delivery result codes and the bus widths.
package secded_pkg;

    localparam int DATO_W    = 4;
    localparam int PALABRA_W = 8;
    localparam int CONT_W    = 8;

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        CARGA      = 3'd1,
        LATENCIA_W = 3'd2,
        EVALUA     = 3'd3,
        ENTREGA    = 3'd4
    } estado_fsm_t;

    typedef enum logic [1:0] {
        LIMPIO      = 2'b00,
        CORREGIDO   = 2'b01,
        REINTENTADO = 2'b10,
        FALLA       = 2'b11
    } estado_salida_t;

endpackage

// File: rtl/controlador_secded_if.sv
// Request/delivery bus between a requester (master) and the SECDED controller (slave).
interface controlador_secded_if;
    import secded_pkg::*;

    logic                 inicio;
    logic [DATO_W-1:0]    dato_entrada;
    logic [PALABRA_W-1:0] patron_error;
    logic                 listo;
    logic                 salida_valida;
    logic [DATO_W-1:0]    salida_dato;
    logic [1:0]           salida_estado;

    modport master (
        output inicio, dato_entrada, patron_error,
        input  listo, salida_valida, salida_dato, salida_estado
    );

    modport slave (
        input  inicio, dato_entrada, patron_error,
        output listo, salida_valida, salida_dato, salida_estado
    );

endinterface

// File: rtl/contador_sat.sv
// Saturating up-counter with increment enable and synchronous clear.
module contador_sat #(
    parameter int WIDTH = 8
) (
    input  logic             reloj,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cuenta
);

    // Count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge reloj) begin
        if (clr) begin
            cuenta <= '0;
        end else if (inc && (cuenta != {WIDTH{1'b1}})) begin
            cuenta <= cuenta + WIDTH'(1);
        end
    end

endmodule

// File: rtl/controlador_secded.sv
// Transfer controller: drives an external SECDED encode/corrupt/correct datapath,
// retries on double errors and reports the delivered nibble with a result code.
module controlador_secded
    import secded_pkg::*;
#(
    parameter int LATENCIA  = 3,
    parameter int MAX_REINT = 2
) (
    input  logic                 reloj,
    input  logic                 reset,
    controlador_secded_if.slave  bus,
    output logic [DATO_W-1:0]    cod_dato,
    output logic [PALABRA_W-1:0] dec_error,
    input  logic [DATO_W-1:0]    corr_dato,
    input  logic                 corr_simple,
    input  logic                 corr_doble,
    output logic [CONT_W-1:0]    cont_simple,
    output logic [CONT_W-1:0]    cont_doble
);

    estado_fsm_t          estado_r;
    estado_salida_t       res_estado_r;
    logic [DATO_W-1:0]    dato_r;
    logic [DATO_W-1:0]    res_dato_r;
    logic [PALABRA_W-1:0] mascara_r;
    logic [2:0]           reint_r;
    logic [7:0]           espera_r;
    logic                 inc_simple_s;
    logic                 inc_doble_s;

    // A simultaneous single+double flag counts only as a double error
    assign inc_simple_s = (estado_r == EVALUA) && corr_simple && !corr_doble;
    assign inc_doble_s  = (estado_r == EVALUA) && corr_doble;

    // Transfer sequencing; all bus and datapath outputs are registered here
    always_ff @(posedge reloj) begin
        if (reset) begin
            estado_r          <= ESPERA;
            res_estado_r      <= LIMPIO;
            dato_r            <= '0;
            res_dato_r        <= '0;
            mascara_r         <= '0;
            reint_r           <= 3'd0;
            espera_r          <= 8'd0;
            cod_dato          <= '0;
            dec_error         <= '0;
            bus.listo         <= 1'b1;
            bus.salida_valida <= 1'b0;
            bus.salida_dato   <= '0;
            bus.salida_estado <= 2'b00;
        end else begin
            bus.salida_valida <= 1'b0;
            case (estado_r)
                ESPERA: begin
                    if (bus.inicio) begin
                        dato_r    <= bus.dato_entrada;
                        mascara_r <= bus.patron_error;
                        reint_r   <= 3'd0;
                        bus.listo <= 1'b0;
                        estado_r  <= CARGA;
                    end
                end
                CARGA: begin
                    cod_dato  <= dato_r;
                    dec_error <= mascara_r;
                    espera_r  <= 8'd0;
                    estado_r  <= LATENCIA_W;
                end
                LATENCIA_W: begin
                    if (espera_r == 8'(LATENCIA - 1)) begin
                        estado_r <= EVALUA;
                    end else begin
                        espera_r <= espera_r + 8'd1;
                    end
                end
                EVALUA: begin
                    res_dato_r <= corr_dato;
                    if (corr_doble) begin
                        // reint_r only climbs from 0, so inequality is "still below limit"
                        if (reint_r != 3'(MAX_REINT)) begin
                            reint_r   <= reint_r + 3'd1;
                            mascara_r <= '0;
                            estado_r  <= CARGA;
                        end else begin
                            res_estado_r <= FALLA;
                            estado_r     <= ENTREGA;
                        end
                    end else begin
                        if (reint_r != 3'd0) begin
                            res_estado_r <= REINTENTADO;
                        end else if (corr_simple) begin
                            res_estado_r <= CORREGIDO;
                        end else begin
                            res_estado_r <= LIMPIO;
                        end
                        estado_r <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    bus.salida_valida <= 1'b1;
                    bus.salida_dato   <= res_dato_r;
                    bus.salida_estado <= res_estado_r;
                    bus.listo         <= 1'b1;
                    estado_r          <= ESPERA;
                end
                default: begin
                    bus.listo <= 1'b1;
                    estado_r  <= ESPERA;
                end
            endcase
        end
    end

    contador_sat #(.WIDTH(CONT_W)) u_cont_simple (
        .reloj  (reloj),
        .clr    (reset),
        .inc    (inc_simple_s),
        .cuenta (cont_simple)
    );

    contador_sat #(.WIDTH(CONT_W)) u_cont_doble (
        .reloj  (reloj),
        .clr    (reset),
        .inc    (inc_doble_s),
        .cuenta (cont_doble)
    );

endmodule

// File: doc/controlador_secded.md
CONTROLADOR_SECDED -- requirements
Module: controlador_secded

Interface
REQ-001 Parameter LATENCIA, default 3: number of clock cycles from datapath input change to a valid corr_* result (encoder, decoder and correction stages are each registered).
REQ-002 Parameter MAX_REINT, default 2: maximum retransmissions after a double-error result; range 0..7.
REQ-003 reloj  input  1  the single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 inicio  input  1  request valid; a transfer is accepted on the edge where inicio=1 and listo=1.
REQ-006 dato_entrada  input  4  data nibble to transmit; sampled on the accept edge.
REQ-007 patron_error  input  8  error mask for the first attempt; sampled on the accept edge.
REQ-008 listo  output  1  controller idle and able to accept a request.
REQ-009 cod_dato  output  4  nibble driven to the encoder.
REQ-010 dec_error  output  8  error mask driven to the decoder.
REQ-011 corr_dato  input  4  corrected nibble from the correction stage.
REQ-012 corr_simple  input  1  single error detected by the correction stage.
REQ-013 corr_doble  input  1  double error detected by the correction stage.
REQ-014 salida_valida  output  1  one-cycle pulse marking a completed transfer.
REQ-015 salida_dato  output  4  delivered nibble; valid while salida_valida=1 and held until the next delivery.
REQ-016 salida_estado  output  2  result code: 00 LIMPIO, 01 CORREGIDO, 10 REINTENTADO, 11 FALLA; held alongside salida_dato.
REQ-017 cont_simple  output  8  saturating count of single-error evaluations.
REQ-018 cont_doble  output  8  saturating count of double-error evaluations.

Function
REQ-019 FSM states: ESPERA, CARGA, LATENCIA_W, EVALUA, ENTREGA; listo=1 only in ESPERA.
REQ-020 ESPERA -> CARGA on the accept edge; capture dato_entrada into a data register, capture patron_error into a mask register, and clear the retry counter.
REQ-021 CARGA lasts 1 cycle; cod_dato and dec_error are driven from the registers and held stable through EVALUA.
REQ-022 LATENCIA_W lasts exactly LATENCIA cycles, counted by a wait counter, then goes to EVALUA.
REQ-023 EVALUA lasts 1 cycle; it samples corr_dato, corr_simple and corr_doble.
REQ-024 EVALUA outcomes:
- corr_doble=1 and retry count < MAX_REINT: increment the retry count, clear the mask register to 0, go to CARGA.
- corr_doble=1 and retries exhausted: go to ENTREGA with FALLA.
- corr_doble=0: go to ENTREGA.
REQ-025 corr_simple=1 and corr_doble=1 together are treated as a double error.
REQ-026 Status on a non-failing delivery:
- REINTENTADO if any retry occurred.
- Otherwise CORREGIDO if corr_simple=1.
- Otherwise LIMPIO.
REQ-027 ENTREGA lasts 1 cycle: salida_valida=1, salida_dato = corr_dato sampled in the final EVALUA (also for FALLA), then go to ESPERA.
REQ-028 Timing: salida_valida rises LATENCIA+3 cycles after the accept edge; each retry adds LATENCIA+2 cycles.
REQ-029 inicio while listo=0 is ignored and is not queued.
REQ-030 Counters increment in EVALUA (cont_simple when corr_simple=1 and corr_doble=0; cont_doble when corr_doble=1) and saturate at 255 without wrapping.
REQ-031 An accept can occur on the cycle immediately after ENTREGA; back-to-back transfers have no extra bubble.

Reset
REQ-032 While reset=1, on the clock edge:
- State goes to ESPERA.
- listo=1, salida_valida=0.
- salida_dato, salida_estado, cod_dato, dec_error, both counters, and the retry and wait counters are set to 0.
REQ-033 Reset asserted mid-transfer aborts it: no salida_valida is produced and the counters are cleared.

Structure
REQ-034 A shared package secded_pkg holds:
- the FSM state enum;
- the salida_estado codes;
- the width constants DATO_W=4, PALABRA_W=8, CONT_W=8.
REQ-035 One sub-module, contador_sat (a parameterised-width saturating counter with increment enable and synchronous clear), is instantiated twice.

Verification
REQ-036 The bench models the datapath with a LATENCIA-deep delay stage that returns encoded/corrected data.
REQ-037 dato_entrada=4'hA, patron_error=0 -> salida_dato=4'hA, estado=00, counters unchanged, pulse 6 cycles after accept.
REQ-038 4'h5 with patron_error=8'h04 -> salida_dato=4'h5, estado=01, cont_simple=1.
REQ-039 4'h3 with patron_error=8'h0C -> one retry with dec_error=0, salida_dato=4'h3, estado=10, cont_doble=1, pulse at 11 cycles.
REQ-040 MAX_REINT=0 with double-error mask -> estado=11, pulse at 6 cycles; also inicio pulsed during busy -> ignored; 300 single-error transfers -> cont_simple=255.
REQ-041 Reset asserted during LATENCIA_W -> no pulse, listo=1 next cycle, counters 0.
